// File: rtl/iosys_mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM port between a cpu and a dma requester.
// Latency: valid in IDLE at cycle 0 -> rv_valid at 1; rv_ready at k -> ready pulse at k+1; next rv_valid no earlier than k+3.
// Backpressure: requesters hold valid until ready; accesses with no rv_ready for TIMEOUT cycles are aborted.
module iosys_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [22:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    input  logic        dma_valid,
    output logic        dma_ready,
    input  logic [22:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_wstrb,
    output logic [31:0] req_rdata,
    output logic        rv_valid,
    input  logic        rv_ready,
    output logic [22:0] rv_addr,
    output logic [31:0] rv_wdata,
    output logic [3:0]  rv_wstrb,
    input  logic [31:0] rv_rdata,
    input  logic        ram_busy,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_dma_q, last_dma_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic        rv_valid_q, rv_valid_d;
    logic [22:0] rv_addr_q, rv_addr_d;
    logic [31:0] rv_wdata_q, rv_wdata_d;
    logic [3:0]  rv_wstrb_q, rv_wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        dma_ready_q, dma_ready_d;
    logic        terr_q, terr_d;
    logic        pick_dma;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_dma_d  = last_dma_q;
        cnt_d       = cnt_q;
        rv_valid_d  = rv_valid_q;
        rv_addr_d   = rv_addr_q;
        rv_wdata_d  = rv_wdata_q;
        rv_wstrb_d  = rv_wstrb_q;
        rdata_d     = rdata_q;
        cpu_ready_d = 1'b0;
        dma_ready_d = 1'b0;
        terr_d      = terr_q;
        // dma wins only when cpu is idle or cpu was the last one served
        pick_dma    = dma_valid && (!cpu_valid || !last_dma_q);

        case (state_q)
            IDLE: begin
                if (!ram_busy && (cpu_valid || dma_valid)) begin
                    grant_d    = pick_dma ? 2'b10 : 2'b01;
                    last_dma_d = pick_dma;
                    rv_addr_d  = pick_dma ? dma_addr  : cpu_addr;
                    rv_wdata_d = pick_dma ? dma_wdata : cpu_wdata;
                    rv_wstrb_d = pick_dma ? dma_wstrb : cpu_wstrb;
                    rv_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (rv_ready) begin
                    rdata_d     = rv_rdata;
                    rv_valid_d  = 1'b0;
                    cpu_ready_d = grant_q[0];
                    dma_ready_d = grant_q[1];
                    state_d     = RECOVER;
                end else begin
                    cnt_d = cnt_inc;
                    // completion on the same cycle takes priority over the abort
                    if (cnt_inc == CW'(TIMEOUT)) begin
                        rdata_d     = 32'hFFFF_FFFF;
                        rv_valid_d  = 1'b0;
                        terr_d      = 1'b1;
                        cpu_ready_d = grant_q[0];
                        dma_ready_d = grant_q[1];
                        state_d     = RECOVER;
                    end
                end
            end
            RECOVER: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                grant_d    = 2'b00;
                rv_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_dma_q  <= 1'b1;
            cnt_q       <= '0;
            rv_valid_q  <= 1'b0;
            rv_addr_q   <= '0;
            rv_wdata_q  <= '0;
            rv_wstrb_q  <= '0;
            rdata_q     <= '0;
            cpu_ready_q <= 1'b0;
            dma_ready_q <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_dma_q  <= last_dma_d;
            cnt_q       <= cnt_d;
            rv_valid_q  <= rv_valid_d;
            rv_addr_q   <= rv_addr_d;
            rv_wdata_q  <= rv_wdata_d;
            rv_wstrb_q  <= rv_wstrb_d;
            rdata_q     <= rdata_d;
            cpu_ready_q <= cpu_ready_d;
            dma_ready_q <= dma_ready_d;
            terr_q      <= terr_d;
        end
    end

    assign cpu_ready   = cpu_ready_q;
    assign dma_ready   = dma_ready_q;
    assign req_rdata   = rdata_q;
    assign rv_valid    = rv_valid_q;
    assign rv_addr     = rv_addr_q;
    assign rv_wdata    = rv_wdata_q;
    assign rv_wstrb    = rv_wstrb_q;
    assign grant       = grant_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_iosys_mem_arbiter.sv
// Bench for iosys_mem_arbiter: directed scenarios then random traffic checked
// against a transaction-level model of arbitration, latency and timeout rules.
module tb_iosys_mem_arbiter;

    localparam int TMO = 4;

    logic        clk;
    logic        resetn;
    logic        cpu_valid, dma_valid;
    logic        cpu_ready, dma_ready;
    logic [22:0] cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic [3:0]  cpu_wstrb, dma_wstrb;
    logic [31:0] req_rdata;
    logic        rv_valid, rv_ready;
    logic [22:0] rv_addr;
    logic [31:0] rv_wdata;
    logic [3:0]  rv_wstrb;
    logic [31:0] rv_rdata;
    logic        ram_busy;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Requester-side model state
    logic        pend    [2];
    logic [22:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_wstrb [2];
    int          last_srv;
    logic        exp_terr;

    iosys_mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wstrb  (cpu_wstrb),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_wstrb  (dma_wstrb),
        .req_rdata  (req_rdata),
        .rv_valid   (rv_valid),
        .rv_ready   (rv_ready),
        .rv_addr    (rv_addr),
        .rv_wdata   (rv_wdata),
        .rv_wstrb   (rv_wstrb),
        .rv_rdata   (rv_rdata),
        .ram_busy   (ram_busy),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_valids();
        cpu_valid = pend[0];
        dma_valid = pend[1];
        cpu_addr  = p_addr[0];
        dma_addr  = p_addr[1];
        cpu_wdata = p_wdata[0];
        dma_wdata = p_wdata[1];
        cpu_wstrb = p_wstrb[0];
        dma_wstrb = p_wstrb[1];
    endtask

    task automatic new_req(input int r);
        pend[r]    = 1'b1;
        p_addr[r]  = 23'($urandom());
        p_wdata[r] = $urandom();
        p_wstrb[r] = 4'($urandom());
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_valids();
        ram_busy = 1'b0;
        rv_ready = 1'b0;
        tick();
        tick();
        resetn   = 1'b1;
        last_srv = 1;
        exp_terr = 1'b0;
    endtask

    // One access: starts while the DUT is idle, ends in the following idle cycle.
    // lat = rv_valid cycle (1-based) on which the SDRAM answers.
    task automatic run_txn(input int busy_cyc, input int lat, input logic [31:0] rd);
        int         w;
        int         n;
        int         exp_n;
        logic       to;
        logic [1:0] eg;
        if (pend[0] && pend[1]) w = (last_srv == 0) ? 1 : 0;
        else if (pend[0])       w = 0;
        else                    w = 1;
        eg    = (w == 0) ? 2'b01 : 2'b10;
        to    = (lat > TMO);
        exp_n = to ? TMO : lat;
        drive_valids();
        for (int i = 0; i < busy_cyc; i++) begin
            ram_busy = 1'b1;
            rv_ready = 1'($urandom_range(0, 1));
            rv_rdata = $urandom();
            tick();
            chk("busy_rv_valid", rv_valid, 0);
            chk("busy_grant", grant, 0);
        end
        ram_busy = 1'b0;
        rv_ready = 1'($urandom_range(0, 1));
        rv_rdata = $urandom();
        tick();
        chk("grant", grant, eg);
        n = 0;
        while (rv_valid === 1'b1 && n < TMO + 2) begin
            n++;
            chk("rv_addr", rv_addr, p_addr[w]);
            chk("rv_wdata", rv_wdata, p_wdata[w]);
            chk("rv_wstrb", rv_wstrb, p_wstrb[w]);
            chk("access_ready", {cpu_ready, dma_ready}, 0);
            rv_ready = (n == lat);
            rv_rdata = (n == lat) ? rd : $urandom();
            ram_busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                if (w == 0) cpu_valid = 1'b0;
                else        dma_valid = 1'b0;
            end
            tick();
        end
        if (to) exp_terr = 1'b1;
        chk("access_cycles", n, exp_n);
        chk("rv_valid_drop", rv_valid, 0);
        chk("winner_ready", (w == 0) ? cpu_ready : dma_ready, 1);
        chk("other_ready", (w == 0) ? dma_ready : cpu_ready, 0);
        chk("req_rdata", req_rdata, to ? 32'hFFFF_FFFF : rd);
        chk("grant_held", grant, eg);
        chk("timeout_err", timeout_err, exp_terr);
        pend[w]  = 1'b0;
        last_srv = w;
        drive_valids();
        rv_ready = 1'($urandom_range(0, 1));
        ram_busy = 1'($urandom_range(0, 1));
        tick();
        chk("idle_grant", grant, 0);
        chk("idle_ready", {cpu_ready, dma_ready}, 0);
        chk("idle_rv_valid", rv_valid, 0);
        chk("idle_timeout_err", timeout_err, exp_terr);
    endtask

    initial begin
        resetn   = 1'b0;
        ram_busy = 1'b0;
        rv_ready = 1'b0;
        rv_rdata = '0;
        for (int r = 0; r < 2; r++) begin
            pend[r]    = 1'b0;
            p_addr[r]  = '0;
            p_wdata[r] = '0;
            p_wstrb[r] = '0;
        end
        drive_valids();
        last_srv = 1;
        exp_terr = 1'b0;
        tick();
        chk("rst_rv_valid", rv_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ready", {cpu_ready, dma_ready}, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_req_rdata", req_rdata, 0);
        chk("rst_rv_addr", rv_addr, 0);
        chk("rst_rv_wdata", rv_wdata, 0);
        chk("rst_rv_wstrb", rv_wstrb, 0);
        resetn = 1'b1;

        // single cpu read
        pend[0]    = 1'b1;
        p_addr[0]  = 23'h000100;
        p_wdata[0] = 32'h0;
        p_wstrb[0] = 4'h0;
        run_txn(0, 3, 32'h1234_5678);

        // contention from reset, both kept requesting: cpu, dma, cpu, dma
        reset_dut();
        new_req(0);
        new_req(1);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order_pending", {pend[0], pend[1]}, 2'b11);
            run_txn(0, 2, $urandom());
            chk("rr_order", last_srv, i % 2);
            if (!pend[0]) new_req(0);
            if (!pend[1]) new_req(1);
        end

        // dma write that never completes, then timeout_err must stay set
        reset_dut();
        new_req(1);
        p_wstrb[1] = 4'hF;
        run_txn(0, 1000, 32'h0);
        new_req(0);
        run_txn(1, 1, 32'hCAFE_F00D);

        // completion on exactly the TIMEOUT-th cycle is not a timeout
        reset_dut();
        new_req(0);
        run_txn(0, TMO, 32'hA5A5_5A5A);

        // ram_busy holds off grants for 10 cycles
        new_req(0);
        run_txn(10, 2, 32'h0BAD_BEEF);

        // reset in the middle of an access, with timeout_err set beforehand
        new_req(1);
        run_txn(0, TMO + 1, 32'h0);
        new_req(0);
        drive_valids();
        ram_busy = 1'b0;
        rv_ready = 1'b0;
        tick();
        chk("mid_rst_access", rv_valid, 1);
        tick();
        resetn = 1'b0;
        #1;
        chk("mid_rst_rv_valid", rv_valid, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_ready", {cpu_ready, dma_ready}, 0);
        chk("mid_rst_req_rdata", req_rdata, 0);
        chk("mid_rst_rv_addr", rv_addr, 0);
        chk("mid_rst_timeout_err", timeout_err, 0);
        rv_ready = 1'b1;
        tick();
        chk("mid_rst_no_ready", {cpu_ready, dma_ready}, 0);
        resetn   = 1'b1;
        rv_ready = 1'b0;
        last_srv = 1;
        exp_terr = 1'b0;
        run_txn(0, 2, 32'h7777_1111);

        // random traffic
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 1) == 1) new_req(r);
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(1, TMO + 2)), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/iosys_mem_arbiter.md
IOSYS_MEM_ARBITER -- requirements
Module: iosys_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles an SDRAM access may wait for rv_ready before it is aborted.
REQ-002 SHALL have port clk  in  1: single clock; all logic is in this domain.
REQ-003 SHALL have port resetn  in  1: asynchronous, active-low reset.
REQ-004 SHALL have ports cpu_valid, dma_valid  in  1 each: requester access request, held until the matching ready.
REQ-005 SHALL have ports cpu_ready, dma_ready  out  1 each: one-cycle completion pulse to the requester.
REQ-006 SHALL have ports cpu_addr, dma_addr  in  23 each: byte address.
REQ-007 SHALL have ports cpu_wdata, dma_wdata  in  32 each: write data.
REQ-008 SHALL have ports cpu_wstrb, dma_wstrb  in  4 each: byte strobes; 0 = read.
REQ-009 SHALL have port req_rdata  out  32: read data, valid while either ready is high.
REQ-010 SHALL have ports rv_valid (out 1), rv_ready (in 1), rv_addr (out 23), rv_wdata (out 32), rv_wstrb (out 4), rv_rdata (in 32): shared SDRAM port.
REQ-011 SHALL have port ram_busy  in  1: SDRAM initialising; no grants while high.
REQ-012 SHALL have port grant  out  2: 00 none, 01 cpu, 10 dma.
REQ-013 SHALL have port timeout_err  out  1: sticky abort flag.

Function
REQ-014 SHALL implement states IDLE, ACCESS, RECOVER.
REQ-015 IDLE: if ram_busy=0 and any valid, SHALL register the winner's addr/wdata/wstrb, set grant, enter ACCESS next cycle.
REQ-016 Arbitration SHALL be round-robin: both valid -> grant requester not served last; one valid -> grant it.
REQ-017 The last-served pointer SHALL reset to dma, so cpu wins the first contention.
REQ-018 ACCESS: rv_valid SHALL be 1 and rv_addr/rv_wdata/rv_wstrb SHALL come from the registered copy, stable for the whole access.
REQ-019 ACCESS + rv_ready: SHALL register rv_rdata into req_rdata, pulse granted ready next cycle, drop rv_valid next cycle, enter RECOVER.
REQ-020 RECOVER: SHALL last exactly 1 cycle with ready pulsing, grant held, no new grant; then IDLE with grant=00.
REQ-021 Latency: valid sampled in IDLE at cycle 0 -> rv_valid at 1 -> rv_ready at k -> ready at k+1 -> earliest next rv_valid at k+3.
REQ-022 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without rv_ready.
REQ-023 Counter = TIMEOUT without rv_ready: SHALL drop rv_valid, set req_rdata=32'hFFFF_FFFF, set timeout_err, enter RECOVER with ready pulse.
REQ-024 rv_ready in the same cycle the counter reaches TIMEOUT SHALL count as normal completion; no timeout_err.
REQ-025 rv_ready outside ACCESS SHALL be ignored.
REQ-026 Requester valid dropped mid-access SHALL not abort the access; the ready pulse still occurs.
REQ-027 ram_busy rising during ACCESS SHALL not abort the access; it only blocks new grants.
REQ-028 Only the granted requester SHALL ever see ready; the other's ready stays 0.
REQ-029 Outputs SHALL be registered; no combinational path from cpu_*/dma_* to rv_*.

Reset
REQ-030 resetn=0 SHALL asynchronously force IDLE, rv_valid=0, cpu_ready=dma_ready=0, grant=00, timeout_err=0, req_rdata=0, rv_addr/rv_wdata/rv_wstrb=0, counter=0, pointer=dma.
REQ-031 Reset mid-ACCESS SHALL abandon the access with no ready pulse; operation resumes from IDLE after release.

Verification
REQ-032 Single read: cpu_valid, addr 0x000100, wstrb 0; rv_ready after 3 cycles with rv_rdata 0x12345678 -> one cpu_ready pulse, req_rdata 0x12345678, dma_ready 0.
REQ-033 Contention: cpu and dma valid together from reset, both held -> grants cpu, dma, cpu, dma; rv_addr matches grantee every access.
REQ-034 Timeout: TIMEOUT=4, dma write, rv_ready never -> rv_valid high 4 cycles, dma_ready pulse, req_rdata 0xFFFFFFFF, timeout_err stays 1 until reset.
REQ-035 Boundary: rv_ready on the cycle counter reaches TIMEOUT -> normal completion, timeout_err 0.
REQ-036 ram_busy=1 with cpu_valid high 10 cycles -> rv_valid 0; ram_busy falls -> rv_valid within 2 cycles.
REQ-037 resetn pulsed low mid-ACCESS -> outputs at reset values immediately, no ready pulse; cpu re-requesting after release completes normally.
